// File: rtl/mult_seq_ctrl_if.sv
// Handshake and operand/result bundle between the execute stage and the mult sequencer.
// The controller side drives the slave modport's inputs; the sequencer returns status and HI/LO.
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             signed_i;
    logic             flush_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             busy_o;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, signed_i, flush_i, src1_i, src2_i,
        input  busy_o, stall_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, signed_i, flush_i, src1_i, src2_i,
        output busy_o, stall_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Radix-2 shift-add sequencer for mult/multu: WIDTH RUN cycles, DONE pulse in cycle WIDTH+1.
// Holds the pipeline via a combinational stall while running; HI/LO update only on completion.
module mult_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mult_seq_ctrl_if.slave mult_if
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_step;
    logic               w_finish;
    logic               w_busy;
    logic               w_stall;
    logic               w_done;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_prod;

    // The most negative operand negates to itself, which read unsigned is exactly its magnitude.
    assign w_mag1 = (mult_if.signed_i && mult_if.src1_i[WIDTH-1]) ? -mult_if.src1_i : mult_if.src1_i;
    assign w_mag2 = (mult_if.signed_i && mult_if.src2_i[WIDTH-1]) ? -mult_if.src2_i : mult_if.src2_i;

    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
    assign w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        w_busy      = 1'b0;
        w_stall     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mult_if.start_i && !mult_if.flush_i) begin
                    w_accept    = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy  = 1'b1;
                w_stall = 1'b1;
                if (mult_if.flush_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        w_finish    = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            if (w_accept) begin
                r_mcand  <= w_mag1;
                r_mplier <= w_mag2;
                r_neg    <= mult_if.signed_i & (mult_if.src1_i[WIDTH-1] ^ mult_if.src2_i[WIDTH-1]);
                r_acc    <= '0;
                r_cnt    <= CNT_W'(WIDTH);
            end else if (w_step) begin
                r_acc    <= w_acc_nxt;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CNT_W'(1);
            end
            if (w_finish) begin
                r_hi <= w_prod[2*WIDTH-1:WIDTH];
                r_lo <= w_prod[WIDTH-1:0];
            end
        end
    end

    assign mult_if.busy_o  = w_busy;
    assign mult_if.stall_o = w_stall;
    assign mult_if.done_o  = w_done;
    assign mult_if.hi_o    = r_hi;
    assign mult_if.lo_o    = r_lo;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed and randomized checks of the mult sequencer against a plain-arithmetic product model.
module tb_mult_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    always #5 clk = ~clk;

    mult_seq_ctrl_if #(.WIDTH(32)) mif ();

    mult_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .mult_if (mif)
    );

    // Sign-extend to 64 bits and multiply modulo 2^64: equals the true signed product's bits.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'd0, a};
        eb = s ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input bit hold);
        logic [63:0] p;
        int nbusy;
        int dcyc;
        p = ref_prod(a, b, s);
        @(negedge clk);
        mif.start_i  = 1'b1;
        mif.src1_i   = a;
        mif.src2_i   = b;
        mif.signed_i = s;
        mif.flush_i  = 1'b0;
        #1;
        chk("stall_accept", 64'(mif.stall_o), 64'd1);
        nbusy = 0;
        dcyc  = 0;
        for (int c = 1; c <= 40 && dcyc == 0; c++) begin
            @(negedge clk);
            if (!hold) begin
                mif.start_i  = 1'b0;
                mif.src1_i   = $urandom();
                mif.src2_i   = $urandom();
                mif.signed_i = 1'($urandom_range(1));
            end
            #1;
            if (mif.busy_o) nbusy++;
            if (mif.done_o) begin
                dcyc = c;
                chk("stall_in_done", 64'(mif.stall_o), 64'd0);
            end
        end
        chk("done_cycle", 64'(dcyc), 64'd33);
        chk("busy_cycles", 64'(nbusy), 64'd32);
        exp_hi = p[63:32];
        exp_lo = p[31:0];
        chk("product", {mif.hi_o, mif.lo_o}, p);
        if (hold) begin
            @(negedge clk);
            #1;
            chk("hold_idle_busy", 64'(mif.busy_o), 64'd0);
            chk("hold_idle_stall", 64'(mif.stall_o), 64'd1);
            @(negedge clk);
            mif.start_i = 1'b0;
            #1;
            chk("hold_reaccept_busy", 64'(mif.busy_o), 64'd1);
            dcyc = 0;
            for (int c = 2; c <= 40 && dcyc == 0; c++) begin
                @(negedge clk);
                #1;
                if (mif.done_o) dcyc = c;
            end
            chk("hold_second_done", 64'(dcyc), 64'd33);
            chk("hold_second_product", {mif.hi_o, mif.lo_o}, p);
        end
        @(negedge clk);
        #1;
        chk("done_one_pulse", 64'(mif.done_o), 64'd0);
        chk("idle_after_done", 64'(mif.busy_o), 64'd0);
    endtask

    initial begin
        int ndone;
        logic [31:0] ra;
        logic [31:0] rb;
        rst          = 1'b1;
        mif.start_i  = 1'b0;
        mif.signed_i = 1'b0;
        mif.flush_i  = 1'b0;
        mif.src1_i   = '0;
        mif.src2_i   = '0;
        exp_hi       = '0;
        exp_lo       = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 64'(mif.busy_o), 64'd0);
        chk("rst_done", 64'(mif.done_o), 64'd0);
        chk("rst_stall", 64'(mif.stall_o), 64'd0);
        chk("rst_hilo", {mif.hi_o, mif.lo_o}, 64'd0);
        rst = 1'b0;

        run_op(32'd3, 32'd5, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("umax_hi", 64'(mif.hi_o), 64'hFFFF_FFFE);
        run_op(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
        chk("neg2x3_lo", 64'(mif.lo_o), 64'hFFFF_FFFA);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("m1xm1", {mif.hi_o, mif.lo_o}, 64'd1);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        chk("minxmin", {mif.hi_o, mif.lo_o}, 64'h4000_0000_0000_0000);
        run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0);
        run_op(32'd0, 32'h1234_5678, 1'b1, 1'b0);

        // Flush mid-run: the 3*5 result must survive an aborted 7*7.
        run_op(32'd3, 32'd5, 1'b0, 1'b0);
        @(negedge clk);
        mif.start_i  = 1'b1;
        mif.src1_i   = 32'd7;
        mif.src2_i   = 32'd7;
        mif.signed_i = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            mif.start_i = 1'b0;
            if (c == 10) mif.flush_i = 1'b1;
            #1;
            if (c == 10) chk("flush_stall_run", 64'(mif.stall_o), 64'd1);
            if (c == 11) begin
                chk("flush_busy", 64'(mif.busy_o), 64'd0);
                mif.flush_i = 1'b0;
            end
        end
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (mif.done_o) ndone++;
        end
        chk("flush_no_done", 64'(ndone), 64'd0);
        chk("flush_hilo_kept", {mif.hi_o, mif.lo_o}, {exp_hi, exp_lo});

        // Start and flush together in IDLE: flush wins.
        @(negedge clk);
        mif.start_i = 1'b1;
        mif.flush_i = 1'b1;
        #1;
        chk("idle_flush_stall", 64'(mif.stall_o), 64'd0);
        @(negedge clk);
        #1;
        chk("idle_flush_busy", 64'(mif.busy_o), 64'd0);
        mif.start_i = 1'b0;
        mif.flush_i = 1'b0;

        run_op(32'hFFFF_FFF9, 32'd6, 1'b1, 1'b1);

        // Reset in cycle 20 of a run.
        @(negedge clk);
        mif.start_i  = 1'b1;
        mif.src1_i   = 32'hDEAD_BEEF;
        mif.src2_i   = 32'h0BAD_F00D;
        mif.signed_i = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            mif.start_i = 1'b0;
            if (c == 20) rst = 1'b1;
            #1;
            if (c == 21) begin
                chk("rst_run_busy", 64'(mif.busy_o), 64'd0);
                chk("rst_run_hilo", {mif.hi_o, mif.lo_o}, 64'd0);
                rst = 1'b0;
            end
        end
        exp_hi = '0;
        exp_lo = '0;
        ndone  = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (mif.done_o) ndone++;
        end
        chk("rst_run_no_done", 64'(ndone), 64'd0);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom();
            rb = $urandom();
            if (i % 5 == 1) ra = 32'h8000_0000;
            if (i % 7 == 2) rb = 32'hFFFF_FFFF;
            run_op(ra, rb, 1'($urandom_range(1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
